// File: rtl/vissue_if.sv
// vissue_if: issue-side and beat-side signals between the vector issue sequencer and its neighbours.
interface vissue_if #(
    parameter int VL_BITS    = 12,
    parameter int BEAT_BITS  = 12,
    parameter int LANE_BYTES = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_is_cfg;
    logic [VL_BITS-1:0]    in_vl;
    logic [2:0]            in_vsew;
    logic                  in_vill;
    logic                  dp_busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [BEAT_BITS-1:0]  out_beat;
    logic [LANE_BYTES-1:0] out_be;
    logic                  out_last;
    logic                  cfg_commit;
    logic                  done;
    modport master (
        output in_valid, in_is_cfg, in_vl, in_vsew, in_vill, dp_busy, out_ready,
        input  in_ready, out_valid, out_beat, out_be, out_last, cfg_commit, done
    );
    modport slave (
        input  in_valid, in_is_cfg, in_vl, in_vsew, in_vill, dp_busy, out_ready,
        output in_ready, out_valid, out_beat, out_be, out_last, cfg_commit, done
    );
endinterface

// File: rtl/vissue_seq.sv
// vissue_seq: splits a vector op into datapath beats with byte enables, and sequences vset* config commits.
module vissue_seq #(
    parameter int VLEN       = 16384,
    parameter int VLMAX      = VLEN / 8,
    parameter int VL_BITS    = $clog2(VLMAX) + 1,
    parameter int LANE_BYTES = 8,
    parameter int BEAT_BITS  = $clog2(VLMAX * 8 / LANE_BYTES) + 1
) (
    input  logic       clk,
    input  logic       rst,
    vissue_if.slave    bus
);
    localparam int TW = VL_BITS + 3;
    localparam int LB_SH = $clog2(LANE_BYTES);
    typedef enum logic [1:0] {IDLE, RUN, CFG_WAIT, CFG_COMMIT} state_t;
    state_t state, state_nxt;
    logic [TW-1:0] total, rem;
    logic [BEAT_BITS-1:0] beat;
    logic done_q, last, hs, acc, vec_go;
    logic [LANE_BYTES-1:0] be;
    // remaining bytes from the current beat onward; beat*LANE_BYTES always fits in TW bits
    assign rem    = total - (TW'(beat) << LB_SH);
    assign last   = rem <= TW'(LANE_BYTES);
    assign acc    = state == IDLE && bus.in_valid;
    assign vec_go = acc && !bus.in_is_cfg && !bus.in_vill && bus.in_vl != '0;
    assign hs     = state == RUN && bus.out_ready;
    always_comb begin
        be = '0;
        for (int i = 0; i < LANE_BYTES; i++) be[i] = !last || (TW'(i) < rem);
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE && acc)
            state_nxt = bus.in_is_cfg ? (bus.dp_busy ? CFG_WAIT : CFG_COMMIT) : (vec_go ? RUN : IDLE);
        else if (state == RUN)
            state_nxt = hs && last ? IDLE : RUN;
        else if (state == CFG_WAIT)
            state_nxt = bus.dp_busy ? CFG_WAIT : CFG_COMMIT;
        else if (state == CFG_COMMIT)
            state_nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            total  <= '0;
            beat   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (acc && !bus.in_is_cfg && !vec_go) || (hs && last);
            if (vec_go) begin
                total <= TW'(bus.in_vl) << bus.in_vsew;
                beat  <= '0;
            end else if (hs) begin
                beat  <= beat + 1'b1;
            end
        end
    end
    assign bus.in_ready   = state == IDLE;
    assign bus.out_valid  = state == RUN;
    assign bus.out_beat   = state == RUN ? beat : '0;
    assign bus.out_be     = state == RUN ? be : '0;
    assign bus.out_last   = state == RUN && last;
    assign bus.cfg_commit = state == CFG_COMMIT;
    assign bus.done       = done_q || state == CFG_COMMIT;
endmodule

// File: tb/tb_vissue_seq.sv
// tb_vissue_seq: directed checks of beat splitting, stalls, empty ops, cfg commit and reset.
module tb_vissue_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    int lasts, gaps;
    always #5 clk = ~clk;
    vissue_if #(.VL_BITS(12), .BEAT_BITS(12), .LANE_BYTES(8)) bus ();
    vissue_seq dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_beat(input string tag, input logic v, input int b, input logic [7:0] be, input logic l, input logic d);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, ".beat"}, 32'(bus.out_beat), 32'(b));
        chk({tag, ".be"}, 32'(bus.out_be), 32'(be));
        chk({tag, ".last"}, 32'(bus.out_last), 32'(l));
        chk({tag, ".done"}, 32'(bus.done), 32'(d));
    endtask
    task automatic issue(input logic cfg, input int vl, input int vsew, input logic vill);
        bus.in_valid = 1'b1;
        bus.in_is_cfg = cfg;
        bus.in_vl = 12'(vl);
        bus.in_vsew = 3'(vsew);
        bus.in_vill = vill;
        chk("accept.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_is_cfg = 1'b0;
        bus.in_vill = 1'b0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        bus.in_valid = 0; bus.in_is_cfg = 0; bus.in_vl = '0; bus.in_vsew = '0;
        bus.in_vill = 0; bus.dp_busy = 0; bus.out_ready = 1;
        tick(); tick();
        chk_beat("reset", 0, 0, 8'h00, 0, 0);
        chk("reset.cfg_commit", 32'(bus.cfg_commit), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_reset.in_ready", 32'(bus.in_ready), 32'd1);
        // vl=5, 32-bit elements: 20 bytes over three 8-byte beats
        issue(0, 5, 2, 0);
        chk_beat("v5.b0", 1, 0, 8'hFF, 0, 0);
        chk("v5.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk_beat("v5.b1", 1, 1, 8'hFF, 0, 0);
        tick();
        chk_beat("v5.b2", 1, 2, 8'h0F, 1, 0);
        tick();
        chk_beat("v5.done", 0, 0, 8'h00, 0, 1);
        chk("v5.in_ready_after", 32'(bus.in_ready), 32'd1);
        tick();
        chk("v5.done_clear", 32'(bus.done), 32'd0);
        // vl=16 bytes with stall on beat 0
        bus.out_ready = 0;
        issue(0, 16, 0, 0);
        chk_beat("v16.stall0", 1, 0, 8'hFF, 0, 0);
        tick();
        chk_beat("v16.stall1", 1, 0, 8'hFF, 0, 0);
        tick();
        chk_beat("v16.stall2", 1, 0, 8'hFF, 0, 0);
        bus.out_ready = 1;
        tick();
        chk_beat("v16.b1", 1, 1, 8'hFF, 1, 0);
        tick();
        chk_beat("v16.done", 0, 0, 8'h00, 0, 1);
        tick();
        // empty ops
        issue(0, 0, 1, 0);
        chk_beat("vl0", 0, 0, 8'h00, 0, 1);
        chk("vl0.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("vl0.done_once", 32'(bus.done), 32'd0);
        issue(0, 8, 0, 1);
        chk_beat("vill", 0, 0, 8'h00, 0, 1);
        chk("vill.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("vill.done_once", 32'(bus.done), 32'd0);
        // cfg while datapath busy for 3 cycles
        bus.dp_busy = 1;
        issue(1, 0, 0, 0);
        chk("cfgw1.in_ready", 32'(bus.in_ready), 32'd0);
        chk("cfgw1.commit", 32'(bus.cfg_commit), 32'd0);
        tick();
        chk("cfgw2.in_ready", 32'(bus.in_ready), 32'd0);
        chk("cfgw2.commit", 32'(bus.cfg_commit), 32'd0);
        tick();
        bus.dp_busy = 0;
        chk("cfgw3.in_ready", 32'(bus.in_ready), 32'd0);
        chk("cfgw3.commit", 32'(bus.cfg_commit), 32'd0);
        tick();
        chk("cfgc.commit", 32'(bus.cfg_commit), 32'd1);
        chk("cfgc.done", 32'(bus.done), 32'd1);
        chk("cfgc.in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("cfg_end.commit", 32'(bus.cfg_commit), 32'd0);
        chk("cfg_end.done", 32'(bus.done), 32'd0);
        chk("cfg_end.in_ready", 32'(bus.in_ready), 32'd1);
        // cfg with idle datapath commits immediately
        issue(1, 0, 0, 0);
        chk("cfgi.commit", 32'(bus.cfg_commit), 32'd1);
        tick();
        chk("cfgi.end", 32'(bus.cfg_commit), 32'd0);
        // reset mid-run of a 64-beat op
        issue(0, 64, 3, 0);
        repeat (4) tick();
        chk_beat("v64.b4", 1, 4, 8'hFF, 0, 0);
        rst = 1;
        tick();
        chk_beat("rst_mid", 0, 0, 8'h00, 0, 0);
        chk("rst_mid.commit", 32'(bus.cfg_commit), 32'd0);
        rst = 0;
        tick();
        chk_beat("rst_after", 0, 0, 8'h00, 0, 0);
        issue(0, 1, 0, 0);
        chk_beat("v1.b0", 1, 0, 8'h01, 1, 0);
        tick();
        chk_beat("v1.done", 0, 0, 8'h00, 0, 1);
        tick();
        // max length: 2048 x 64-bit = 16384 bytes = 2048 beats
        issue(0, 2048, 3, 0);
        lasts = 0;
        gaps = 0;
        for (int i = 0; i < 2047; i++) begin
            if (bus.out_last) lasts++;
            if (!bus.out_valid) gaps++;
            tick();
        end
        chk("vmax.early_last", 32'(lasts), 32'd0);
        chk("vmax.gaps", 32'(gaps), 32'd0);
        chk_beat("vmax.final", 1, 2047, 8'hFF, 1, 0);
        tick();
        chk_beat("vmax.done", 0, 0, 8'h00, 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vissue_seq.md
VISSUE_SEQ -- requirements
Module: vissue_seq

Interface
REQ-001 Parameter VLEN, default 16384, vector register length in bits.
REQ-002 Parameter VLMAX, default VLEN/8, maximum vl.
REQ-003 Parameter VL_BITS, default $clog2(VLMAX)+1, vl width.
REQ-004 Parameter LANE_BYTES, default 8, datapath bytes per beat; power of two, 4..64.
REQ-005 Parameter BEAT_BITS, default $clog2(VLMAX*8/LANE_BYTES)+1, beat index width.
REQ-006 clk  input  1  clock; rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  instruction offered.
REQ-008 in_ready  output  1  instruction accepted when in_valid & in_ready.
REQ-009 in_is_cfg  input  1  instruction is vsetvl/vsetvli/vsetivli.
REQ-010 in_vl  input  VL_BITS  current vl, for vector ops.
REQ-011 in_vsew  input  3  current vsew encoding: 0=8b, 1=16b, 2=32b, 3=64b.
REQ-012 in_vill  input  1  current vtype illegal.
REQ-013 dp_busy  input  1  downstream datapath has results in flight.
REQ-014 out_valid  output  1  beat valid.
REQ-015 out_ready  input  1  datapath accepts beat.
REQ-016 out_beat  output  BEAT_BITS  beat index, starts at 0.
REQ-017 out_be  output  LANE_BYTES  byte enables for the beat.
REQ-018 out_last  output  1  final beat of the op.
REQ-019 cfg_commit  output  1  one-cycle strobe to the config unit valid.
REQ-020 done  output  1  one-cycle strobe marking op or cfg completion.

Function
REQ-021 FSM states: IDLE, RUN, CFG_WAIT, CFG_COMMIT.
REQ-022 in_ready SHALL be 1 only in IDLE; all other states block the input.
REQ-023 IDLE, vector op accepted, in_vill=0, in_vl>0: latch total bytes = in_vl << in_vsew (VL_BITS+3 bits, no overflow); go RUN next cycle.
REQ-024 IDLE, vector op accepted, in_vill=1 or in_vl=0: no beats; done=1 next cycle; stay IDLE.
REQ-025 RUN: out_valid=1; beat count = ceil(total/LANE_BYTES).
REQ-026 RUN: out_beat, out_be, and out_last SHALL hold stable while out_valid & !out_ready.
REQ-027 RUN, out_valid & out_ready: advance out_beat by 1.
REQ-028 out_be: all ones, except on the last beat, where bit i = (i < remaining bytes) and remaining = total - out_beat*LANE_BYTES.
REQ-029 out_last=1 when remaining <= LANE_BYTES.
REQ-030 RUN, handshake with out_last=1: go IDLE; done=1 in the following cycle.
REQ-031 IDLE, cfg accepted: go CFG_WAIT if dp_busy=1, else CFG_COMMIT.
REQ-032 CFG_WAIT: remain while dp_busy=1; go CFG_COMMIT the cycle after dp_busy=0 is sampled.
REQ-033 CFG_COMMIT: cfg_commit=1 and done=1 for exactly one cycle; go IDLE.
REQ-034 Throughput: one beat per cycle under continuous out_ready; the first beat is valid in the cycle after acceptance.
REQ-035 Back-to-back: the next instruction is accepted no earlier than the cycle after the last beat handshake.
REQ-036 Outputs not in use in a state SHALL be 0.

Reset
REQ-037 On rst: state=IDLE, out_valid=0, out_beat=0, out_be=0, out_last=0, cfg_commit=0, done=0, counters cleared; in_ready=1 the cycle after rst deasserts.
REQ-038 rst during RUN or CFG_WAIT: abandon the op with no further beats and no cfg_commit; rst dominates all other inputs.

Verification
REQ-039 LANE_BYTES=8, vl=5, vsew=2: 3 beats, out_be 0xFF, 0xFF, 0x0F; out_last only on beat 2; done one cycle after beat 2.
REQ-040 vl=16, vsew=0, out_ready low for 2 cycles on beat 0: beat 0 held unchanged; 2 beats total, both out_be=0xFF.
REQ-041 vl=0, and separately in_vill=1, vl=8: no out_valid; done pulses once; in_ready=1 again one cycle after acceptance.
REQ-042 cfg accepted with dp_busy high for 3 cycles: cfg_commit is a single pulse one cycle after dp_busy falls; in_ready=0 throughout.
REQ-043 rst asserted mid-RUN of vl=64, vsew=3 (64 beats): all outputs 0 the next cycle, no done pulse; a new op is accepted cleanly.
REQ-044 VLMAX=2048, vl=2048, vsew=3: 16384 bytes gives exactly 2048 beats; last beat out_be=0xFF; no width overflow.
